// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: 16-bit binary -> BCD via iterative double-dabble,
// then time-multiplexed digit/an drive. Optional `DISPLAY_LEADING_ZERO_BLANK_EN blanks leading zeros.

module dd_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module display_scan_ctrl #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  output logic        ready,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        overflow
);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
  state_t state, nstate;

  logic [15:0]      bin;
  logic [4:0][3:0]  bcd, adj;
  logic [35:0]      dd_next;
  logic [3:0]       iter;
  logic [3:0][3:0]  disp, commit_val;
  logic [RW-1:0]    rcnt;
  logic [1:0]       idx;

  // add-3 correction per BCD nibble, ten-thousands down to units
  for (genvar g = 0; g < 5; g++) begin : g_adj
    dd_adj u_adj (.d(bcd[g]), .q(adj[g]));
  end

  assign dd_next = {adj, bin} << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (load) nstate = CONVERT;
      CONVERT: if (iter == 4'd15) nstate = COMMIT;
      COMMIT:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
  end

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  logic lead;
`endif

  always_comb begin
    commit_val = bcd[3:0];
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    lead = 1'b1;
`endif
    if (bcd[4] != 4'd0) begin
      commit_val = {4{4'hF}};
    end
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    else begin
      // blank from thousands down, stopping at the first nonzero; units always shown
      for (int i = 3; i >= 1; i--) begin
        if (lead && commit_val[i] == 4'd0) commit_val[i] = 4'hF;
        else                               lead = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin      <= '0;
      bcd      <= '0;
      iter     <= '0;
      disp     <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          bin  <= value;
          bcd  <= '0;
          iter <= '0;
        end
        CONVERT: begin
          {bcd, bin} <= dd_next;
          iter       <= iter + 4'd1;
        end
        COMMIT: begin
          disp     <= commit_val;
          overflow <= (bcd[4] != 4'd0);
        end
        default: ;
      endcase
    end
  end

  // free-running scan, independent of conversion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  assign an    = ~(4'b0001 << idx);
  assign digit = disp[idx];

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: accepted loads push the expected display image,
// a negedge monitor pops on each ready rise and checks scan outputs every cycle.

module tb_display_scan_ctrl;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset, load;
  logic [15:0] value;
  logic        ready, overflow;
  logic [3:0]  digit, an;

  display_scan_ctrl #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .ready(ready), .digit(digit), .an(an), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][3:0] d;
    logic            ovf;
  } exp_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int v);
    exp_t e;
    if (v > 9999) begin
      e.d   = {4{4'hF}};
      e.ovf = 1'b1;
    end else begin
      e.ovf  = 1'b0;
      e.d[0] = 4'(v % 10);
      e.d[1] = 4'((v / 10) % 10);
      e.d[2] = 4'((v / 100) % 10);
      e.d[3] = 4'((v / 1000) % 10);
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
      for (int i = 3; i >= 1; i--) begin
        if (e.d[i] != 4'd0) break;
        e.d[i] = 4'hF;
      end
`endif
    end
    return e;
  endfunction

  // reference state, owned by the monitor
  exp_t            q[$];
  logic [3:0][3:0] mdisp;
  logic            movf;
  logic            prev_ready;
  int              busy;
  int              k;

  always @(negedge clk) begin
    exp_t e;
    int   ix;
    logic [3:0] exp_an;
    if (reset) begin
      q.delete();
      mdisp      = '0;
      movf       = 1'b0;
      prev_ready = 1'b1;
      busy       = 0;
      k          = 0;
      chk("rst_ready", int'(ready), 1);
      chk("rst_an", int'(an), 4'b1110);
      chk("rst_digit", int'(digit), 0);
      chk("rst_ovf", int'(overflow), 0);
    end else begin
      if (ready && !prev_ready) begin
        chk("busy_len", busy, 17);
        busy = 0;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL commit_unexpected act=commit exp=none t=%0t", $time);
        end else begin
          e     = q.pop_front();
          mdisp = e.d;
          movf  = e.ovf;
        end
      end
      if (!ready) busy++;
      ix     = (k / RD) % 4;
      exp_an = ~(4'b0001 << ix);
      chk("an", int'(an), int'(exp_an));
      chk("digit", int'(digit), int'(mdisp[ix]));
      chk("overflow", int'(overflow), int'(movf));
      if (ready && load) q.push_back(model(int'(value)));
      prev_ready = ready;
      k++;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ready) return;
    end
    total++;
    bad++;
    $display("FAIL wait_ready act=timeout exp=ready t=%0t", $time);
  endtask

  task automatic send(input logic [15:0] v);
    wait_idle();
    load  = 1'b1;
    value = v;
    @(posedge clk); #1;
    load  = 1'b0;
  endtask

  task automatic async_reset_check(input string nm);
    reset = 1'b1;
    #1;
    chk({nm, "_ready"}, int'(ready), 1);
    chk({nm, "_an"}, int'(an), 4'b1110);
    chk({nm, "_digit"}, int'(digit), 0);
    chk({nm, "_ovf"}, int'(overflow), 0);
    @(posedge clk); #3;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;

    send(16'd1234);
    wait_idle();
    repeat (18) @(posedge clk);

    send(16'd10000);
    send(16'd9999);
    wait_idle();
    repeat (16) @(posedge clk);

    // load while busy must be ignored
    send(16'd42);
    repeat (2) @(posedge clk);
    #1 load = 1'b1; value = 16'd7;
    @(posedge clk); #1 load = 1'b0;
    wait_idle();
    repeat (16) @(posedge clk);

    send(16'd0);
    send(16'd1005);
    send(16'd5);
    wait_idle();
    repeat (16) @(posedge clk);

    // reset mid-frame
    repeat (6) @(posedge clk);
    #2;
    async_reset_check("rst_mid");
    repeat (5) @(posedge clk);

    for (int n = 0; n < 20; n++) begin
      send(16'($urandom_range(0, 65535)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 10)) @(posedge clk);
        #1 load = 1'b1; value = 16'($urandom);
        @(posedge clk); #1 load = 1'b0;
      end
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end

    // held load re-triggers; value changes every cycle
    wait_idle();
    load = 1'b1;
    for (int n = 0; n < 60; n++) begin
      value = 16'($urandom_range(0, 12000));
      @(posedge clk); #1;
    end
    load = 1'b0;
    wait_idle();
    repeat (16) @(posedge clk);

    // reset during CONVERT: nothing is committed afterwards
    send(16'd65535);
    repeat (7) @(posedge clk);
    #2;
    async_reset_check("rst_conv");
    repeat (40) @(posedge clk);

    #1 chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Sequential controller for the board's four-digit seven-segment display. It accepts a 16-bit binary value through a load/ready handshake and converts it to four BCD digits with an iterative shift-add-3 (double-dabble) engine. It then time-multiplexes those digits through a single instance of the team's BCD-to-segment decoder by driving that decoder's 4-bit `sum` input and the active-low digit enables. It sits between the processor's result/register-view bus and the display pins.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clock cycles each digit stays enabled before the scan advances. Legal range is ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load`  in  1  request to display `value`; sampled only while `ready`=1.
- `value`  in  16  unsigned binary value to display.
- `ready`  out  1  high when idle and able to accept `load`.
- `digit`  out  4  BCD code of the currently scanned digit; feeds the decoder `sum` input. 4'hF means blank, because the decoder blanks codes above 9.
- `an`  out  4  active-low digit enables, exactly one low at a time. `an[0]` is the units digit and `an[3]` is the thousands digit.
- `overflow`  out  1  high when the last committed value exceeded 9999.

## Operation
- **FSM states:** IDLE, CONVERT, COMMIT.
- **IDLE:**
  - `ready`=1.
  - `load`=1 captures `value` into the shift register, clears the 20-bit BCD accumulator, sets the iteration count to 0 and moves to CONVERT.
- **CONVERT:**
  - One double-dabble iteration per cycle: add 3 to each BCD nibble that is ≥ 5, then shift {BCD, binary} left by 1.
  - After 16 iterations, move to COMMIT.
  - `ready`=0.
  - `load` is ignored.
- **COMMIT:**
  - One cycle.
  - If the ten-thousands nibble is nonzero: all four display registers are set to 4'hF and `overflow`=1.
  - Otherwise: the display registers are loaded with the thousands, hundreds, tens and units nibbles, and `overflow`=0.
  - Moves to IDLE.
- **Display during conversion:** the display registers hold the previous value throughout CONVERT. The scan never stalls.
- **Scan:**
  - The refresh counter counts 0..REFRESH_DIV-1. On wrap, the scan index advances 0→1→2→3→0.
  - `an` = ~(4'b0001 << idx).
  - `digit` = display register[idx].
  - The scan runs continuously and independently of the FSM.

## Timing
- **Reset values:**
  - FSM = IDLE, `ready`=1, `overflow`=0.
  - Display registers = 0, so `digit`=4'h0.
  - Scan index = 0, so `an`=4'b1110.
  - Refresh counter = 0.
- **Load latency:**
  - `load` is sampled at edge N.
  - `ready` is low from edge N until edge N+17.
  - The display registers and `overflow` update at edge N+17, and `ready`=1 again after edge N+17.
- **Continuous loading:** `load` held high continuously re-triggers at the first edge on which `ready`=1. There is no queueing.
- **Scan rate:** each digit is enabled for exactly REFRESH_DIV cycles, giving a full frame of 4·REFRESH_DIV cycles.
- **Glitch-free outputs:** `an` and `digit` are registered (or decoded from registered index/state only), so they do not glitch.
- **Commit on a scan wrap:** the new value appears on the currently enabled digit in the same cycle. No blank cycle is inserted.
- **Reset during CONVERT or COMMIT:** the conversion is aborted immediately and all outputs return to their reset values. The aborted value is never committed.

## Configuration
- **`DISPLAY_LEADING_ZERO_BLANK_EN` defined:**
  - In COMMIT, when not overflowing, leading zero digits are replaced by 4'hF.
  - Blanking runs from thousands downward and stops at the first nonzero digit.
  - The units digit is never blanked. Examples: 42 shows as F,F,4,2 and 0 shows as F,F,F,0.
- **Not defined:** all four digits are shown, including leading zeros. Example: 42 shows as 0,0,4,2.

## Test plan
- **Reset:** assert `reset` mid-frame → asynchronously `an`=4'b1110, `digit`=0, `ready`=1, `overflow`=0.
- **Basic conversion and scan:** REFRESH_DIV=4, `load`=1 with `value`=1234 →
  - `ready`=0 for 17 cycles;
  - then `digit`/`an` cycle 4/1110, 3/1101, 2/1011, 1/0111, each for 4 cycles;
  - `overflow`=0.
- **Overflow:** `value`=10000 → all digits 4'hF and `overflow`=1. A following `value`=9999 → digits 9,9,9,9 and `overflow`=0.
- **Load while busy is ignored:** load 42, then pulse `load` with `value`=7 three cycles later → display shows 42. Expected digits are 0,0,4,2, or F,F,4,2 with the macro defined.
- **Leading-zero blanking (macro defined):**
  - `value`=0 → F,F,F,0;
  - `value`=1005 → 1,0,0,5 (interior zeros not blanked).
  - With the macro undefined, `value`=0 → 0,0,0,0.
- **Reset mid-conversion:** load 65535 and assert `reset` at cycle 8 of CONVERT → `ready`=1 and `digit`=0 immediately. After release, no commit occurs and `overflow` stays 0.
